sub64_byte_serial: RTL

//   Multi-cycle unsigned subtractor: diff = a - b - bin over WIDTH bits, one BLK-bit block per cycle.
//   Per-block borrow generate/propagate feeds a registered borrow chain, the borrow-side

---
 rtl/sub64_byte_serial.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sub64_byte_serial.sv
// sub64_byte_serial: multi-cycle unsigned subtractor, diff = a - b - bin.
// One BLK-bit block is resolved per clock through a registered borrow chain
// (per-block borrow generate/propagate), trading throughput for area.
// Optional build macro: SUB64_SATURATE_EN (unsigned floor at zero on borrow-out).
module sub64_byte_serial #(
    parameter int WIDTH = 64,
    parameter int BLK   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int NBLK = WIDTH / BLK;
    localparam int IW   = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBLK - 1);

    if (WIDTH % BLK != 0) begin : g_width_check
        $error("sub64_byte_serial: WIDTH must be a multiple of BLK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    idx;
    logic             borrow;
    logic [WIDTH-1:0] a_r, b_r, acc;
    logic [BLK-1:0]   a_blk, b_blk, d_blk;
    logic             g_blk, p_blk, borrow_nxt;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] res_final;
    logic             accept, finish;

`ifdef SUB64_SATURATE_EN
    // Unsigned saturation: any borrow-out means the true result is negative,
    // which clamps to zero.
    function automatic logic [WIDTH-1:0] sat_floor(input logic [WIDTH-1:0] wrapped,
                                                   input logic             under);
        return under ? '0 : wrapped;
    endfunction
    assign res_final = sat_floor(acc_nxt, borrow_nxt);
`else
    assign res_final = acc_nxt;
`endif

    assign accept = (state == IDLE) && in_valid;
    assign finish = (state == RUN) && (idx == LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (idx == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Current block: borrow generate/propagate and wrapped block difference
    always_comb begin
        a_blk      = a_r[idx*BLK +: BLK];
        b_blk      = b_r[idx*BLK +: BLK];
        g_blk      = (a_blk < b_blk);
        p_blk      = (a_blk == b_blk);
        d_blk      = a_blk - b_blk - BLK'(borrow);
        borrow_nxt = g_blk | (p_blk & borrow);
        acc_nxt    = acc;
        acc_nxt[idx*BLK +: BLK] = d_blk;
    end

    // Block index, borrow chain and published result; diff/bout only change
    // on the final block so no partial result is ever visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else if (accept) begin
            idx    <= '0;
            borrow <= bin;
        end else if (state == RUN) begin
            borrow <= borrow_nxt;
            if (finish) begin
                idx  <= '0;
                diff <= res_final;
                bout <= borrow_nxt;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Operand capture and working accumulator (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= a;
            b_r <= b;
        end
        if (state == RUN) acc <= acc_nxt;
    end

endmodule
